rsa_mod_prod: RTL and testbench

Montgomery-domain entry stage for the RSA core. It computes o_result = i_a · 2^SHIFT mod i_n by SHIFT iterations of modular doubling. Its result is the operand that the Montgomery multiplier directly downstream consumes. The decryptor starts it once per message, and once for the base, before the square-and-multiply loop.

---
 rtl/rsa_pkg.sv | 12 +
 rtl/rsa_mod_prod_if.sv | 23 ++
 rtl/rsa_mod_prod_double.sv | 20 ++
 rtl/rsa_mod_prod.sv | 120 ++++++++++++
 tb/tb_rsa_mod_prod.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA core control blocks: default operand width
// and the common two-state control enum.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } rsa_state_e;

endpackage

// File: rtl/rsa_mod_prod_if.sv
// Request/result bundle for rsa_mod_prod; master issues operands, slave computes.
interface rsa_mod_prod_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
);

  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_a, i_n,
    input  o_result, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_a, i_n,
    output o_result, o_finished, o_busy
  );

endinterface

// File: rtl/rsa_mod_prod_double.sv
// mod_double: one combinational modular doubling step, r = 2t mod n for t < n.
module mod_double #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
) (
  input  logic [WIDTH:0]   t,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   r
);

  logic [WIDTH:0] t2;
  logic [WIDTH:0] n_ext;

  // The shifted value can exceed WIDTH bits, so the compare keeps the carry bit.
  always_comb begin
    t2    = t << 1;
    n_ext = {1'b0, n};
    r     = (t2 >= n_ext) ? (t2 - n_ext) : t2;
  end

endmodule

// File: rtl/rsa_mod_prod.sv
// Montgomery-domain entry: o_result = i_a * 2^SHIFT mod i_n by repeated doubling.
// Define RSA_MOD_PROD_RADIX4_EN to apply two doubling steps per cycle.
module rsa_mod_prod
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int SHIFT = 256
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rsa_mod_prod_if.slave  bus
);

`ifdef RSA_MOD_PROD_RADIX4_EN
  localparam int STEPS = SHIFT / 2;
`else
  localparam int STEPS = SHIFT;
`endif
  localparam int CNT_W = $clog2(SHIFT + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if (SHIFT < 1) begin : g_bad_shift
      $error("rsa_mod_prod: SHIFT must be at least 1");
    end
`ifdef RSA_MOD_PROD_RADIX4_EN
    if ((SHIFT % 2) != 0) begin : g_odd_shift
      $error("rsa_mod_prod: SHIFT must be even when radix-4 stepping is enabled");
    end
`endif
  endgenerate

  rsa_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   t_q, t_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             finished_q, finished_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   t_step1;
  logic [WIDTH:0]   t_next;

  mod_double #(.WIDTH(WIDTH)) u_double0 (
    .t (t_q),
    .n (n_q),
    .r (t_step1)
  );

`ifdef RSA_MOD_PROD_RADIX4_EN
  mod_double #(.WIDTH(WIDTH)) u_double1 (
    .t (t_step1),
    .n (n_q),
    .r (t_next)
  );
`else
  assign t_next = t_step1;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      t_q        <= '0;
      n_q        <= '0;
      result_q   <= '0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      n_q        <= n_d;
      result_q   <= result_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
    end
  end

  // Starts are only honoured from idle; the completion cycle is already idle,
  // which is what lets a new request follow with no gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    n_d        = n_q;
    result_d   = result_q;
    finished_d = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          t_d     = {1'b0, bus.i_a};
          n_d     = bus.i_n;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        t_d = t_next;
        if (cnt_q == LAST_STEP) begin
          result_d   = t_next[WIDTH-1:0];
          finished_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_result   = result_q;
  assign bus.o_finished = finished_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_rsa_mod_prod.sv
// Directed bench for rsa_mod_prod: an 8-bit and a 256-bit instance share clock and reset.
module tb_rsa_mod_prod;

`ifdef RSA_MOD_PROD_RADIX4_EN
  localparam int LAT8   = 4;
  localparam int LAT256 = 128;
`else
  localparam int LAT8   = 8;
  localparam int LAT256 = 256;
`endif

  logic clock;
  logic i_rst;

  int assertCount = 0;
  int failCount   = 0;

  rsa_mod_prod_if #(.WIDTH(8))   bus8 ();
  rsa_mod_prod_if #(.WIDTH(256)) bus256 ();

  rsa_mod_prod #(.WIDTH(8), .SHIFT(8)) dut8 (
    .i_clk (clock),
    .i_rst (i_rst),
    .bus   (bus8.slave)
  );

  rsa_mod_prod #(.WIDTH(256), .SHIFT(256)) dut256 (
    .i_clk (clock),
    .i_rst (i_rst),
    .bus   (bus256.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit           wide;
    logic [255:0] a;
    logic [255:0] n;
    logic [255:0] expv;
    string        name;
  } vec_t;

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] readResult(input bit wide);
    return wide ? bus256.o_result : {248'b0, bus8.o_result};
  endfunction

  function automatic logic readFinished(input bit wide);
    return wide ? bus256.o_finished : bus8.o_finished;
  endfunction

  function automatic logic readBusy(input bit wide);
    return wide ? bus256.o_busy : bus8.o_busy;
  endfunction

  // Drive a start at the negedge; returns just after the accepting edge E0.
  task automatic applyStimulus(input bit wide, input logic [255:0] a, input logic [255:0] n);
    @(negedge clock);
    if (wide) begin
      bus256.i_start = 1'b1;
      bus256.i_a     = a;
      bus256.i_n     = n;
    end else begin
      bus8.i_start = 1'b1;
      bus8.i_a     = a[7:0];
      bus8.i_n     = n[7:0];
    end
    @(posedge clock);
    #1;
    bus8.i_start   = 1'b0;
    bus256.i_start = 1'b0;
  endtask

  // Counts edges after E0 until o_finished, bounded by a cycle budget.
  task automatic waitFinished(input bit wide, output int cycles);
    cycles = 0;
    while (!readFinished(wide) && cycles < 400) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  task automatic runVector(input vec_t v);
    int cycles;
    int lat;
    lat = v.wide ? LAT256 : LAT8;
    applyStimulus(v.wide, v.a, v.n);
    checkOutput({v.name, " busy"}, 256'(readBusy(v.wide)), 256'd1);
    waitFinished(v.wide, cycles);
    checkOutput({v.name, " latency"}, 256'(cycles), 256'(lat));
    checkOutput({v.name, " result"}, readResult(v.wide), v.expv);
    @(posedge clock);
    #1;
    checkOutput({v.name, " pulse width"}, 256'(readFinished(v.wide)), 256'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [255:0] n256;
    int cycles;
    bit sawFinish;

    n256 = '1;
    n256 = n256 - 256'd188;
    vecs[0] = '{1'b0, 256'd1,   256'd251, 256'd5,   "n251 a=1"};
    vecs[1] = '{1'b0, 256'd100, 256'd251, 256'd249, "n251 a=100"};
    vecs[2] = '{1'b0, 256'd0,   256'd251, 256'd0,   "n251 a=0"};
    vecs[3] = '{1'b1, 256'd1,   n256,     256'd189, "wide a=1"};
    vecs[4] = '{1'b1, 256'd2,   n256,     256'd378, "wide a=2"};
    vecs[5] = '{1'b1, n256 - 256'd1, n256, n256 - 256'd189, "wide a=n-1"};

    i_rst          = 1'b0;
    bus8.i_start   = 1'b0;
    bus8.i_a       = '0;
    bus8.i_n       = '0;
    bus256.i_start = 1'b0;
    bus256.i_a     = '0;
    bus256.i_n     = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset result8", readResult(1'b0), 256'd0);
    checkOutput("reset finished8", 256'(bus8.o_finished), 256'd0);
    checkOutput("reset busy8", 256'(bus8.o_busy), 256'd0);
    checkOutput("reset result256", readResult(1'b1), 256'd0);
    @(negedge clock);
    i_rst = 1'b1;

    for (int i = 0; i < 6; i++) runVector(vecs[i]);

    // Mid-run start with different operands must be ignored.
    applyStimulus(1'b0, 256'd100, 256'd251);
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus8.i_start = 1'b1;
    bus8.i_a     = 8'd1;
    bus8.i_n     = 8'd7;
    @(posedge clock);
    #1;
    bus8.i_start = 1'b0;
    waitFinished(1'b0, cycles);
    checkOutput("ignore latency", 256'(cycles + 3), 256'(LAT8));
    checkOutput("ignore result", readResult(1'b0), 256'd249);
    @(posedge clock);
    #1;
    checkOutput("ignore single pulse", 256'(bus8.o_finished), 256'd0);
    checkOutput("ignore idle", 256'(bus8.o_busy), 256'd0);

    // Reset mid-run clears everything and produces no completion.
    applyStimulus(1'b0, 256'd100, 256'd251);
    repeat (2) @(posedge clock);
    @(negedge clock);
    i_rst = 1'b0;
    #1;
    checkOutput("midreset result", readResult(1'b0), 256'd0);
    checkOutput("midreset busy", 256'(bus8.o_busy), 256'd0);
    checkOutput("midreset finished", 256'(bus8.o_finished), 256'd0);
    @(negedge clock);
    i_rst = 1'b1;
    sawFinish = 1'b0;
    for (int c = 0; c < LAT8 + 4; c++) begin
      @(posedge clock);
      #1;
      if (bus8.o_finished) sawFinish = 1'b1;
    end
    checkOutput("midreset no pulse", 256'(sawFinish), 256'd0);
    runVector('{1'b0, 256'd1, 256'd251, 256'd5, "after reset a=1"});

    // Back-to-back: new start held during the completion cycle.
    applyStimulus(1'b0, 256'd100, 256'd251);
    waitFinished(1'b0, cycles);
    checkOutput("b2b first result", readResult(1'b0), 256'd249);
    bus8.i_start = 1'b1;
    bus8.i_a     = 8'd1;
    bus8.i_n     = 8'd251;
    @(posedge clock);
    #1;
    bus8.i_start = 1'b0;
    checkOutput("b2b accepted", 256'(bus8.o_busy), 256'd1);
    waitFinished(1'b0, cycles);
    checkOutput("b2b latency", 256'(cycles), 256'(LAT8));
    checkOutput("b2b result", readResult(1'b0), 256'd5);

    // Operands change right after the start edge; latched copies win.
    applyStimulus(1'b0, 256'd100, 256'd251);
    bus8.i_a = 8'd1;
    bus8.i_n = 8'd7;
    waitFinished(1'b0, cycles);
    checkOutput("stable latency", 256'(cycles), 256'(LAT8));
    checkOutput("stable result", readResult(1'b0), 256'd249);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
